// File: rtl/ecb_row_decryptor.sv
// Streaming ECB row decryptor: XORs BLOCK_SIZE-bit words with a latched key and assembles an HSIZE-bit row.
// Latency: m_valid rises on the edge accepting the last word. Backpressure: s_ready low while a row is held.
// Optional rows_done counter under ECB_DEC_ROW_COUNT_EN.
module ecb_row_decryptor #(
  parameter int BLOCK_SIZE = 32,
  parameter int HSIZE      = 768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BLOCK_SIZE-1:0] key,
  input  logic                  key_load,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BLOCK_SIZE-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [HSIZE-1:0]      m_row,
  output logic                  busy
`ifdef ECB_DEC_ROW_COUNT_EN
  ,
  output logic [15:0]           rows_done
`endif
);

  localparam int WORDS = HSIZE / BLOCK_SIZE;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [BLOCK_SIZE-1:0]              key_q;
  logic [WORDS-1:0][BLOCK_SIZE-1:0]   row_q;
  logic                               accept;

  assign accept = s_valid && s_ready;
  assign m_row  = row_q;

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      key_q   <= '0;
      row_q   <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef ECB_DEC_ROW_COUNT_EN
      rows_done <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The first word of a row still uses the old key even if a load coincides.
          if (key_load) key_q <= key;
          if (accept) begin
            row_q[cnt] <= s_data ^ key_q;
            busy       <= 1'b1;
            if (WORDS == 1) begin
              state   <= HOLD;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
            end else begin
              state <= FILL;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (accept) begin
            row_q[cnt] <= s_data ^ key_q;
            if (cnt == LAST) begin
              cnt     <= '0;
              state   <= HOLD;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
`ifdef ECB_DEC_ROW_COUNT_EN
            rows_done <= rows_done + 16'd1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecb_row_decryptor.sv
// Self-checking bench for ecb_row_decryptor: vector table, corner-case sequences and randomized rows.
module tb_ecb_row_decryptor;
  localparam int BS    = 32;
  localparam int HS    = 768;
  localparam int WORDS = HS / BS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BS-1:0] key;
  logic          key_load;
  logic          s_valid;
  logic          s_ready;
  logic [BS-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [HS-1:0] m_row;
  logic          busy;
`ifdef ECB_DEC_ROW_COUNT_EN
  logic [15:0]   rows_done;
`endif

  ecb_row_decryptor #(.BLOCK_SIZE(BS), .HSIZE(HS)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_load(key_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row), .busy(busy)
`ifdef ECB_DEC_ROW_COUNT_EN
    , .rows_done(rows_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BS-1:0] key;
    logic [BS-1:0] seed;
    logic [BS-1:0] exp;
    int            hold;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            rows_exp = 0;
  logic [BS-1:0] model_key;
  logic [BS-1:0] data [WORDS];
  logic [BS-1:0] expw [WORDS];
  vec_t          vt [6];

  task automatic chk(input string name, input logic [HS-1:0] act, input logic [HS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HS-1:0] pack_exp();
    logic [HS-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*BS +: BS] = expw[i];
    return r;
  endfunction

  task automatic load_key(input logic [BS-1:0] k);
    key_load = 1'b1;
    key = k;
    step();
    key_load = 1'b0;
    model_key = k;
  endtask

  // Pushes data[first..last]; optional key_load on the cycle the first word is offered.
  task automatic push(input int first, input int last, input int gap_lo, input int gap_hi,
                      input bit kl_first, input logic [BS-1:0] kl_val);
    int tries;
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        s_valid = 1'b0;
        step();
      end
      s_valid  = 1'b1;
      s_data   = data[i];
      key_load = kl_first && (i == first);
      key      = kl_val;
      tries = 0;
      while (!s_ready && tries < 50) begin
        step();
        tries++;
      end
      if (tries >= 50) chk("accept_timeout", 1'b0, 1'b1);
      step();
    end
    s_valid  = 1'b0;
    key_load = 1'b0;
  endtask

  task automatic finish_row(input string tag, input int hold);
    logic [HS-1:0] snap;
    chk({tag, "_mvalid_latency"}, m_valid, 1'b1);
    chk({tag, "_sready_hold"}, s_ready, 1'b0);
    chk({tag, "_busy_hold"}, busy, 1'b1);
    snap = m_row;
    m_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      s_valid = 1'b1;
      s_data  = 32'hDEADBEEF;
      step();
      chk({tag, "_bp_mvalid"}, m_valid, 1'b1);
      chk({tag, "_bp_row_stable"}, m_row, snap);
      chk({tag, "_bp_sready"}, s_ready, 1'b0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    rows_exp++;
    chk({tag, "_mvalid_pulse"}, m_valid, 1'b0);
    chk({tag, "_sready_idle"}, s_ready, 1'b1);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_row"}, snap, pack_exp());
  endtask

  task automatic rand_data();
    for (int i = 0; i < WORDS; i++) data[i] = $urandom;
  endtask

  task automatic exp_with(input logic [BS-1:0] k);
    for (int i = 0; i < WORDS; i++) expw[i] = data[i] ^ k;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rows_exp = 0;
    model_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    vt[0] = '{key: 32'hA5A5A5A5, seed: 32'hA5A5A5A5, exp: 32'h00000000, hold: 0};
    vt[1] = '{key: 32'hA5A5A5A5, seed: 32'hA5A5A5A5, exp: 32'h00000000, hold: 10};
    vt[2] = '{key: 32'h00000000, seed: 32'h12345678, exp: 32'h12345678, hold: 0};
    vt[3] = '{key: 32'hFFFFFFFF, seed: 32'h0F0F0F0F, exp: 32'hF0F0F0F0, hold: 2};
    vt[4] = '{key: 32'hDEADBEEF, seed: 32'h00000000, exp: 32'hDEADBEEF, hold: 1};
    vt[5] = '{key: 32'h80000001, seed: 32'h7FFFFFFE, exp: 32'hFFFFFFFF, hold: 0};

    rst_n = 1'b0; key = '0; key_load = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    model_key = '0;
    #12;
    chk("rst_sready", s_ready, 1'b1);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mrow", m_row, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      load_key(vt[v].key);
      for (int i = 0; i < WORDS; i++) begin
        data[i] = vt[v].seed ^ BS'(i);
        expw[i] = vt[v].exp ^ BS'(i);
      end
      push(0, WORDS - 1, 0, 0, 1'b0, '0);
      finish_row($sformatf("vec%0d", v), vt[v].hold);
    end

    // Key load during FILL must not disturb the row in flight.
    load_key(32'hA5A5A5A5);
    rand_data();
    push(0, 5, 0, 0, 1'b0, '0);
    key_load = 1'b1; key = 32'h12345678; step(); key_load = 1'b0;
    push(6, WORDS - 1, 0, 0, 1'b0, '0);
    exp_with(32'hA5A5A5A5);
    finish_row("keyguard", 0);
    rand_data();
    push(0, WORDS - 1, 0, 0, 1'b0, '0);
    exp_with(32'hA5A5A5A5);
    finish_row("keyguard_same", 0);
    load_key(32'h12345678);
    rand_data();
    push(0, WORDS - 1, 0, 0, 1'b0, '0);
    exp_with(32'h12345678);
    finish_row("keyguard_next", 0);

    // Asynchronous reset mid-row.
    rand_data();
    push(0, 11, 0, 0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mvalid", m_valid, 1'b0);
    chk("midrst_sready", s_ready, 1'b1);
    chk("midrst_mrow", m_row, '0);
    rows_exp = 0;
    model_key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rand_data();
    push(0, WORDS - 1, 0, 0, 1'b0, '0);
    exp_with(32'h0);
    finish_row("postrst", 0);

    // Same-edge key load with the first word: word 0 uses the old (zero) key.
    rand_data();
    data[0] = 32'hFFFFFFFF;
    push(0, WORDS - 1, 0, 0, 1'b1, 32'h0F0F0F0F);
    exp_with(32'h0F0F0F0F);
    expw[0] = 32'hFFFFFFFF;
    model_key = 32'h0F0F0F0F;
    finish_row("sameedge", 0);

    // Gapped input, three rows, counter from a clean reset.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      load_key($urandom);
      rand_data();
      push(0, WORDS - 1, 1, 1, 1'b0, '0);
      exp_with(model_key);
      finish_row($sformatf("gap%0d", r), 1);
    end
`ifdef ECB_DEC_ROW_COUNT_EN
    chk("rows_done_3", rows_done, 16'd3);
`endif

    // Randomized rows against the transaction-level model.
    for (int r = 0; r < 12; r++) begin
      logic [BS-1:0] k;
      k = $urandom;
      rand_data();
      m_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) begin
        load_key(k);
        push(0, WORDS - 1, 0, 2, 1'b0, '0);
        exp_with(k);
      end else begin
        push(0, WORDS - 1, 0, 2, 1'b1, k);
        exp_with(k);
        expw[0] = data[0] ^ model_key;
        model_key = k;
      end
      finish_row($sformatf("rnd%0d", r), $urandom_range(0, 3));
    end
`ifdef ECB_DEC_ROW_COUNT_EN
    chk("rows_done_final", rows_done, 16'(rows_exp));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
